bcd_operand_entry: RTL and testbench

- Upstream stage of the 4-bit BCD adder and display path.
- Collects the two BCD operands X and Y one digit at a time. The digit comes from a 4-bit switch field and is committed by a debounced pushbutton press.
- Digits above 9 are rejected and flagged on an error output.
- After both operands are accepted, the block holds X and Y stable with Valid high, and the adder and display stage consumes them directly.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/key_debounce.sv | 46 ++++
 rtl/bcd_operand_entry.sv | 92 +++++++++
 tb/tb_bcd_operand_entry.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD operand entry path: FSM encoding, digit limit
// and debounce lengths (full-rate silicon vs. short simulation runs).
// Latency: n/a. Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    GET_X = 2'b00,
    GET_Y = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int BCD_MAX             = 9;
  localparam int DEBOUNCE_CYCLES_SYN = 500000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/key_debounce.sv
// Purpose: 2-flop synchronizer, debounce counter and press (1->0) pulse for an active-low button.
// Latency: pulse appears 2 + DEBOUNCE_CYCLES cycles after a clean falling edge on key_n.
// Backpressure: none; one pulse per accepted press, release produces nothing.
// Ports: clk, rst_n (async active-low), key_n (raw button, pressed = 0), press (1-cycle pulse).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = bcd_pkg::DEBOUNCE_CYCLES_SYN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Level has differed long enough: accept it. A change away from a
        // high debounced level is a press; the opposite direction is a release.
        db    <= sync2;
        cnt   <= '0;
        press <= db;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Purpose: collects BCD operands X then Y from SW on debounced Load presses; rejects digits > BCD_MAX.
// Latency: outputs update 2 + DEBOUNCE_CYCLES + 1 cycles after a clean Load falling edge.
// Backpressure: none; X/Y held stable with Valid until the next press restarts entry.
// Ports: Clock, Resetn (async active-low), SW[3:0], Load (active-low button),
//        X[3:0], Y[3:0], Valid, Err, State[1:0] (FSM state for LEDs).
module bcd_operand_entry
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] SW,
  input  logic       Load,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       Valid,
  output logic       Err,
  output logic [1:0] State
);

  logic [3:0] sw_s1;
  logic [3:0] sw_s2;
  logic       press;
  state_t     state;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk   (Clock),
    .rst_n (Resetn),
    .key_n (Load),
    .press (press)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= GET_X;
      X     <= '0;
      Y     <= '0;
      Valid <= 1'b0;
      Err   <= 1'b0;
    end else begin
      case (state)
        GET_X: if (press) begin
          if (sw_s2 <= 4'(BCD_MAX)) begin
            X     <= sw_s2;
            Err   <= 1'b0;
            state <= GET_Y;
          end else begin
            Err <= 1'b1;
          end
        end
        GET_Y: if (press) begin
          if (sw_s2 <= 4'(BCD_MAX)) begin
            Y     <= sw_s2;
            Err   <= 1'b0;
            Valid <= 1'b1;
            state <= DONE;
          end else begin
            Err <= 1'b1;
          end
        end
        DONE: if (press) begin
          // X and Y deliberately keep their values until re-entered.
          Valid <= 1'b0;
          Err   <= 1'b0;
          state <= GET_X;
        end
        default: begin
          // Unreachable encoding: recover without waiting for a press.
          Valid <= 1'b0;
          Err   <= 1'b0;
          state <= GET_X;
        end
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Purpose: self-checking bench for bcd_operand_entry with a short debounce length.
// Latency: expected updates scheduled at Load fall + 7 cycles and checked on the falling clock edge.
// Backpressure: n/a.
module tb_bcd_operand_entry;
  import bcd_pkg::*;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] SW;
  logic       Load;
  logic [3:0] X;
  logic [3:0] Y;
  logic       Valid;
  logic       Err;
  logic [1:0] State;

  bcd_operand_entry #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .SW     (SW),
    .Load   (Load),
    .X      (X),
    .Y      (Y),
    .Valid  (Valid),
    .Err    (Err),
    .State  (State)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       v;
    logic       e;
    logic [1:0] st;
  } snap_t;

  typedef struct {
    snap_t prev;
    snap_t nxt;
    int    due;
  } exp_t;

  exp_t  sb[$];
  snap_t model = '0;
  snap_t last  = '0;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic snap_t cur();
    return snap_t'({X, Y, Valid, Err, State});
  endfunction

  // Reference behaviour of one accepted press.
  function automatic snap_t step(snap_t m, logic [3:0] d);
    snap_t r;
    r = m;
    case (m.st)
      2'b00: if (d <= 4'd9) begin r.x = d; r.e = 1'b0; r.st = 2'b01; end
             else r.e = 1'b1;
      2'b01: if (d <= 4'd9) begin r.y = d; r.e = 1'b0; r.v = 1'b1; r.st = 2'b10; end
             else r.e = 1'b1;
      default: begin r.v = 1'b0; r.e = 1'b0; r.st = 2'b00; end
    endcase
    return r;
  endfunction

  // Scoreboard monitor: outputs must stay put until the scheduled cycle, then match.
  always @(negedge Clock) begin
    snap_t c;
    c = cur();
    if (Resetn) begin
      n_vec++;
      if ((Valid && Err) || (Valid && State !== 2'b10)) begin
        n_err++;
        $display("FAIL invariant: Valid=%b Err=%b State=%b, required Valid only in DONE and never with Err",
                 Valid, Err, State);
      end
      if (sb.size() > 0 && cyc == sb[0].due) begin
        n_vec++;
        if (c !== sb[0].nxt) begin
          n_err++;
          $display("FAIL update@%0d: got X=%0d Y=%0d V=%b E=%b St=%b, required X=%0d Y=%0d V=%b E=%b St=%b",
                   cyc, c.x, c.y, c.v, c.e, c.st, sb[0].nxt.x, sb[0].nxt.y, sb[0].nxt.v, sb[0].nxt.e, sb[0].nxt.st);
        end
        void'(sb.pop_front());
      end else if (sb.size() > 0 && cyc == sb[0].due - 1) begin
        n_vec++;
        if (c !== sb[0].prev) begin
          n_err++;
          $display("FAIL early@%0d: got %h, required unchanged %h", cyc, c, sb[0].prev);
        end
      end else if (c !== last) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious@%0d: outputs changed %h -> %h with no event due", cyc, last, c);
      end
    end
    last = c;
  end

  task automatic tick(int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic drain();
    int b;
    b = 40;
    while (sb.size() > 0 && b > 0) begin
      @(posedge Clock);
      b--;
    end
    #1;
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d events outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Clean Load falling edge with digit d; schedules the expected update.
  task automatic fall(logic [3:0] d);
    exp_t e;
    @(posedge Clock);
    #1;
    SW     = d;
    Load   = 1'b0;
    e.prev = model;
    model  = step(model, d);
    e.nxt  = model;
    e.due  = cyc + 7;
    sb.push_back(e);
  endtask

  task automatic press(logic [3:0] d, int hold);
    fall(d);
    tick(hold);
    Load = 1'b1;
    tick(12);
    drain();
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    Load   = 1'b1;
    SW     = 4'd0;
    tick(3);
    n_vec++;
    if (cur() !== snap_t'(0)) begin
      n_err++;
      $display("FAIL reset_out: got %h, required 0", cur());
    end
    n_vec++;
    if (dut.u_deb.cnt !== 2'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d, required 0", dut.u_deb.cnt);
    end
    Resetn = 1'b1;
    model  = '0;
    tick(3);
  endtask

  task automatic test_basic();
    press(4'd3, 10);
    n_vec++;
    if (X !== 4'd3 || State !== 2'b01 || Valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_x: got X=%0d St=%b V=%b, required X=3 St=01 V=0", X, State, Valid);
    end
    press(4'd7, 10);
    n_vec++;
    if (Y !== 4'd7 || Valid !== 1'b1 || State !== 2'b10) begin
      n_err++;
      $display("FAIL basic_y: got Y=%0d V=%b St=%b, required Y=7 V=1 St=10", Y, Valid, State);
    end
  endtask

  task automatic test_error();
    press(4'd0, 10);  // DONE -> GET_X
    press(4'd12, 10);
    n_vec++;
    if (Err !== 1'b1 || State !== 2'b00 || X !== 4'd3) begin
      n_err++;
      $display("FAIL err_reject: got E=%b St=%b X=%0d, required E=1 St=00 X=3", Err, State, X);
    end
    press(4'd5, 10);
    n_vec++;
    if (Err !== 1'b0 || State !== 2'b01 || X !== 4'd5) begin
      n_err++;
      $display("FAIL err_recover: got E=%b St=%b X=%0d, required E=0 St=01 X=5", Err, State, X);
    end
  endtask

  task automatic test_bounce();
    press(4'd1, 10);  // GET_Y -> DONE
    press(4'd0, 10);  // DONE -> GET_X
    SW = 4'd8;
    Load = 1'b0; tick(2);
    Load = 1'b1; tick(1);
    Load = 1'b0; tick(3);
    Load = 1'b1; tick(2);
    Load = 1'b0; tick(1);
    Load = 1'b1; tick(1);
    fall(4'd8);
    tick(20);
    Load = 1'b1;
    tick(12);
    drain();
    n_vec++;
    if (X !== 4'd8 || State !== 2'b01) begin
      n_err++;
      $display("FAIL bounce: got X=%0d St=%b, required X=8 St=01", X, State);
    end
  endtask

  task automatic test_hold();
    press(4'd2, 10);  // GET_Y -> DONE
    press(4'd0, 10);  // DONE -> GET_X
    press(4'd4, 100);
    n_vec++;
    if (X !== 4'd4 || State !== 2'b01 || Valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold: got X=%0d St=%b V=%b, required X=4 St=01 V=0", X, State, Valid);
    end
  endtask

  task automatic test_done();
    press(4'd9, 10);  // GET_Y -> DONE
    press(4'd0, 10);  // DONE -> GET_X
    press(4'd9, 10);
    press(4'd9, 10);
    n_vec++;
    if (X !== 4'd9 || Y !== 4'd9 || Valid !== 1'b1 || State !== 2'b10) begin
      n_err++;
      $display("FAIL done_pre: got X=%0d Y=%0d V=%b St=%b, required 9 9 1 10", X, Y, Valid, State);
    end
    press(4'd0, 10);
    n_vec++;
    if (X !== 4'd9 || Y !== 4'd9 || Valid !== 1'b0 || Err !== 1'b0 || State !== 2'b00) begin
      n_err++;
      $display("FAIL done_exit: got X=%0d Y=%0d V=%b E=%b St=%b, required 9 9 0 0 00",
               X, Y, Valid, Err, State);
    end
  endtask

  task automatic test_reset_mid();
    press(4'd6, 10);
    @(posedge Clock);
    #1;
    SW   = 4'd6;
    Load = 1'b0;
    tick(4);
    n_vec++;
    if (dut.u_deb.cnt !== 2'd2) begin
      n_err++;
      $display("FAIL mid_cnt: got %0d, required 2", dut.u_deb.cnt);
    end
    n_vec++;
    if (X !== 4'd6 || State !== 2'b01) begin
      n_err++;
      $display("FAIL mid_pre: got X=%0d St=%b, required X=6 St=01", X, State);
    end
    Resetn = 1'b0;
    #1;
    n_vec++;
    if (cur() !== snap_t'(0) || dut.u_deb.cnt !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset: got %h cnt=%0d, required 0 cnt=0", cur(), dut.u_deb.cnt);
    end
    Load = 1'b1;
    tick(3);
    Resetn = 1'b1;
    model  = '0;
    tick(20);
    n_vec++;
    if (cur() !== snap_t'(0)) begin
      n_err++;
      $display("FAIL mid_after: got %h, required 0", cur());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_bounce();
    test_hold();
    test_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
